// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
//   md_op_t      : operation code carried on the op port
//   md_state_t   : sequencer states IDLE -> CALC -> FIXUP
//   MD_DIVZERO_Q : fill bit replicated across LO on a divide by zero
//   md_is_signed : true for MULT/DIV (op[0] clear)
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_t;

    localparam logic MD_DIVZERO_Q = 1'b1;

    function automatic logic md_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Core <-> mul/div unit connection.
//   master (core) : drives start/op/rs_data/rt_data/mf_rd/mthi/mtlo/flush,
//                   receives hi/lo/busy/done/stall
//   slave  (unit) : the reverse
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mf_rd;
    logic             mthi;
    logic             mtlo;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_data, rt_data, mf_rd, mthi, mtlo, flush,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_data, rt_data, mf_rd, mthi, mtlo, flush,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the mul/div sequencer (combinational).
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc     : {upper, lower} working register
//             multiply: upper = partial product, lower = remaining multiplier bits
//             divide  : upper = partial remainder, lower = dividend bits / quotient bits
//   opnd    : multiplicand (multiply) or divisor (divide), magnitude only
//   acc_nxt : working register after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // keeping the carry so the right shift brings it into the product.
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        // Divide: remainder shifted left with the next dividend bit (WIDTH+1 bits).
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd});
        // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            acc_nxt = {(ge ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   clk, rst_b : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of mips_muldiv_unit_if (operation request, MFHI/MFLO,
//                MTHI/MTLO, flush in; hi/lo/busy/done/stall out)
// One bit per cycle for WIDTH cycles in CALC, then a FIXUP cycle applies signs
// and commits HI/LO. Operands are held as magnitudes during CALC.
module mips_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    mips_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic               is_div_r, neg_q_r, neg_r_r, divzero_r;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic               accept, commit, mt_ok, calc_last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_r),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    // Operand magnitudes and signs for the request on the bus this cycle.
    always_comb begin
        a_neg = md_is_signed(bus.op) & bus.rs_data[WIDTH-1];
        b_neg = md_is_signed(bus.op) & bus.rt_data[WIDTH-1];
        a_abs = a_neg ? -bus.rs_data : bus.rs_data;
        b_abs = b_neg ? -bus.rt_data : bus.rt_data;
    end

    // Next state and per-cycle enables.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        mt_ok     = 1'b0;
        calc_last = (cnt == CW'(WIDTH - 1));
        case (state)
            MD_IDLE: begin
                if (!bus.flush) begin
                    if (bus.start) begin
                        accept    = 1'b1;
                        state_nxt = MD_CALC;
                    end else begin
                        mt_ok = 1'b1;
                    end
                end
            end
            MD_CALC: begin
                if (bus.flush) begin
                    state_nxt = MD_IDLE;
                end else if (calc_last) begin
                    state_nxt = MD_FIXUP;
                end
            end
            MD_FIXUP: begin
                state_nxt = MD_IDLE;
                commit    = ~bus.flush;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != MD_IDLE);
            done_q <= commit;
            if (accept) begin
                cnt <= '0;
            end else if (state == MD_CALC) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Working registers carry no reset: they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            opnd      <= bus.op[1] ? b_abs : a_abs;
            acc       <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
            is_div_r  <= bus.op[1];
            neg_q_r   <= a_neg ^ b_neg;
            neg_r_r   <= a_neg;
            divzero_r <= bus.op[1] & (bus.rt_data == '0);
        end else if (state == MD_CALC) begin
            acc <= acc_nxt;
        end
    end

    // Sign fixup. A zero divisor leaves |A| in the remainder, so re-applying
    // the sign of A returns the raw dividend in HI.
    always_comb begin
        prod = neg_q_r ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (is_div_r) begin
            lo_fix = divzero_r ? {WIDTH{MD_DIVZERO_Q}} : (neg_q_r ? -quo : quo);
            hi_fix = neg_r_r ? -rem : rem;
        end else begin
            hi_fix = prod[2*WIDTH-1:WIDTH];
            lo_fix = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
        end else begin
            if (mt_ok && bus.mthi) hi_q <= bus.rs_data;
            if (mt_ok && bus.mtlo) lo_q <= bus.rs_data;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.start | bus.mf_rd | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mips_muldiv_unit_if #(.WIDTH(32)) bus();

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.op      = MD_MULT;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.mf_rd   = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.flush   = 1'b0;
    endtask

    // Entered and left on a falling edge.
    task automatic mt_write(input bit to_hi, input logic [31:0] val);
        bus.rs_data = val;
        bus.mthi    = to_hi;
        bus.mtlo    = ~to_hi;
        @(negedge clk);
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
    endtask

    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l,
                         output int nbusy, output bit got);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        h     = '0;
        l     = '0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                got = 1'b1;
                h   = bus.hi;
                l   = bus.lo;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [31:0] h, l;
        int          nb, ndone, cyc;
        bit          got;

        vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
        vecs[2]  = '{MD_MULT,  32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "mult_zero"};
        vecs[3]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7xneg3"};
        vecs[4]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_2p32"};
        vecs[5]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
        vecs[6]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
        vecs[7]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100by7"};
        vecs[8]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0"};
        vecs[9]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_m1"};
        vecs[10] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7by_neg2"};
        vecs[11] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
        vecs[12] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, "divu_max_by2"};

        clear_inputs();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        chk("reset_hi",   bus.hi,   32'h0);
        chk("reset_lo",   bus.lo,   32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        bus.mf_rd = 1'b1;
        #1 chk("idle_mf_no_stall", 32'(bus.stall), 32'h0);
        bus.mf_rd = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, h, l, nb, got);
            chk({vecs[i].name, "_done_seen"}, 32'(got), 32'h1);
            chk({vecs[i].name, "_hi"}, h, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, l, vecs[i].lo);
            chk({vecs[i].name, "_busy_cycles"}, 32'(nb), 32'd33);
            @(negedge clk);
            chk({vecs[i].name, "_done_pulse"}, 32'(bus.done), 32'h0);
        end

        // MTHI / MTLO while idle.
        mt_write(1'b1, 32'h1234_5678);
        chk("mthi_idle", bus.hi, 32'h1234_5678);
        mt_write(1'b0, 32'hABCD_EF01);
        chk("mtlo_idle", bus.lo, 32'hABCD_EF01);

        // Consumers while busy: stall, hi/lo frozen, second start ignored.
        bus.op      = MD_MULTU;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd5;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        got = 1'b0;
        cyc = 1;
        while (!got && cyc < 80) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (cyc == 3) begin
                    bus.op      = MD_MULTU;
                    bus.rs_data = 32'd7;
                    bus.rt_data = 32'd7;
                    bus.start   = 1'b1;
                    #1 chk("start_busy_stall", 32'(bus.stall), 32'h1);
                end else begin
                    bus.start = 1'b0;
                end
                if (cyc == 5) bus.mf_rd = 1'b1;
                if (cyc == 7) begin
                    bus.rs_data = 32'hDEAD_BEEF;
                    bus.mthi    = 1'b1;
                end else begin
                    bus.mthi = 1'b0;
                end
                if (cyc >= 5) begin
                    #1;
                    chk("mf_busy_stall", 32'(bus.stall), 32'h1);
                    chk("mf_busy_hi_hold", bus.hi, 32'h1234_5678);
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk("stall_seq_done_seen", 32'(got), 32'h1);
        chk("stall_seq_done_cycle", 32'(cyc), 32'd34);
        #1 chk("mf_done_no_stall", 32'(bus.stall), 32'h0);
        chk("stall_seq_hi", bus.hi, 32'h0);
        chk("stall_seq_lo", bus.lo, 32'h0000_000F);
        bus.mf_rd = 1'b0;
        @(negedge clk);

        // Flush in IDLE suppresses MTHI.
        bus.flush   = 1'b1;
        bus.mthi    = 1'b1;
        bus.rs_data = 32'h5555_5555;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.mthi  = 1'b0;
        chk("flush_idle_mthi", bus.hi, 32'h0);

        // Flush mid-CALC: op abandoned, hi/lo untouched, no done.
        mt_write(1'b1, 32'h1111_1111);
        mt_write(1'b0, 32'h2222_2222);
        bus.op      = MD_MULTU;
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd5;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy_low", 32'(bus.busy), 32'h0);
        chk("flush_hi", bus.hi, 32'h1111_1111);
        chk("flush_lo", bus.lo, 32'h2222_2222);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) ndone++;
            @(negedge clk);
        end
        chk("flush_no_done", 32'(ndone), 32'h0);
        chk("flush_hi_after", bus.hi, 32'h1111_1111);

        // Asynchronous reset mid-CALC.
        bus.op      = MD_MULTU;
        bus.rs_data = 32'hFFFF_FFFF;
        bus.rt_data = 32'hFFFF_FFFF;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("arst_hi",   bus.hi, 32'h0);
        chk("arst_lo",   bus.lo, 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) ndone++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(ndone), 32'h0);
        chk("arst_hi_after", bus.hi, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
